fog_rate_accum: RTL and testbench

Downstream consumer of the closed-loop feedback step. Sums the per-period feedback step over a window of 2^k modulation periods and publishes a rounded, saturated mean rate word for the host/UART packer. A valid/ready handshake carries the result, with an overrun flag when results are not taken in time. It sits between the feedback step generator's monitor output and the output framing logic.

---
 rtl/fog_pkg.sv | 20 ++
 rtl/fog_round_sat.sv | 48 ++++
 rtl/fog_rate_accum.sv | 158 +++++++++++++++
 tb/tb_fog_rate_accum.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fog_pkg.sv
// fog_pkg: shared types and constants for the rate averaging path.
// Holds the default widths, the FSM state encoding and the k clamp.
package fog_pkg;

    localparam int STEP_W   = 32;
    localparam int ACC_W    = 48;
    localparam int MAX_LOG2 = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Averaging exponents above the supported maximum fall back to it.
    function automatic logic [3:0] clamp_k(input logic [3:0] k);
        return (k > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : k;
    endfunction

endpackage

// File: rtl/fog_round_sat.sv
// fog_round_sat: divide a wide signed sum by 2^k with half-up rounding,
// then clamp the quotient into the signed STEP_W output range.
module fog_round_sat #(
    parameter int STEP_W = 32,
    parameter int ACC_W  = 48
) (
    input  logic [ACC_W-1:0]  i_sum,
    input  logic [3:0]        i_k,
    output logic [STEP_W-1:0] o_rate
);

    // One guard bit so the rounding bias can never wrap the sum.
    localparam int XW = ACC_W + 1;

    localparam logic signed [XW-1:0] LIM_HI =
        {{(XW-STEP_W+1){1'b0}}, {(STEP_W-1){1'b1}}};
    localparam logic signed [XW-1:0] LIM_LO =
        {{(XW-STEP_W+1){1'b1}}, {(STEP_W-1){1'b0}}};

    logic signed [XW-1:0] w_ext;
    logic signed [XW-1:0] w_bias;
    logic signed [XW-1:0] w_rnd;
    logic signed [XW-1:0] w_shr;

    assign w_ext = {i_sum[ACC_W-1], i_sum};

    // Half-LSB bias; k = 0 is a plain pass-through.
    always_comb begin
        w_bias = '0;
        if (i_k != 4'd0) begin
            w_bias = XW'(1) << (i_k - 4'd1);
        end
    end

    assign w_rnd = w_ext + w_bias;
    assign w_shr = w_rnd >>> i_k;

    // Clamp the rounded quotient into the output word range.
    always_comb begin
        o_rate = w_shr[STEP_W-1:0];
        if (w_shr > LIM_HI) begin
            o_rate = LIM_HI[STEP_W-1:0];
        end else if (w_shr < LIM_LO) begin
            o_rate = LIM_LO[STEP_W-1:0];
        end
    end

endmodule

// File: rtl/fog_rate_accum.sv
// fog_rate_accum: sums feedback steps over 2^k periods and publishes a
// rounded, saturated mean rate through a valid/ready port with overrun.
module fog_rate_accum #(
    parameter int STEP_W   = fog_pkg::STEP_W,
    parameter int ACC_W    = fog_pkg::ACC_W,
    parameter int MAX_LOG2 = fog_pkg::MAX_LOG2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [3:0]          i_avg_log2,
    input  logic [STEP_W-1:0]   i_step,
    input  logic                i_step_vld,
    output logic [STEP_W-1:0]   o_rate,
    output logic                o_rate_vld,
    input  logic                i_rate_rdy,
    output logic                o_overrun,
    input  logic                i_clr_ovr,
    output logic [MAX_LOG2:0]   o_win_cnt
);

    import fog_pkg::*;

    localparam logic [MAX_LOG2:0] CNT_ONE = {{MAX_LOG2{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [MAX_LOG2:0]   r_cnt;
    logic [MAX_LOG2:0]   w_cnt_nxt;
    logic [3:0]          r_k;
    logic [3:0]          w_k_nxt;
    logic [3:0]          w_k_in;
    logic [ACC_W-1:0]    w_step_ext;
    logic [MAX_LOG2:0]   w_cnt_inc;
    logic [MAX_LOG2:0]   w_win_len;
    logic                w_load;
    logic [STEP_W-1:0]   w_rnd;
    logic [STEP_W-1:0]   r_rate;
    logic                r_rate_vld;
    logic                r_ovr;

    assign w_k_in     = clamp_k(i_avg_log2);
    assign w_step_ext = {{(ACC_W-STEP_W){i_step[STEP_W-1]}}, i_step};
    assign w_cnt_inc  = r_cnt + CNT_ONE;
    assign w_win_len  = CNT_ONE << r_k;

    // In DONE the accumulator holds the finished window sum.
    fog_round_sat #(
        .STEP_W (STEP_W),
        .ACC_W  (ACC_W)
    ) u_round_sat (
        .i_sum  (r_acc),
        .i_k    (r_k),
        .o_rate (w_rnd)
    );

    // State, accumulator, sample count and exponent registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Window sequencing; a strobe seen in DONE opens the next window.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
                if (i_en) begin
                    w_k_nxt     = w_k_in;
                    w_state_nxt = ST_ACC;
                end
            end
            ST_ACC: begin
                if (!i_en) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (i_step_vld) begin
                    w_acc_nxt = r_acc + w_step_ext;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == w_win_len) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_load    = 1'b1;
                w_k_nxt   = w_k_in;
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
                if (!i_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACC;
                    if (i_step_vld) begin
                        w_acc_nxt = w_step_ext;
                        w_cnt_nxt = CNT_ONE;
                        if (w_k_in == 4'd0) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output word and valid: load on DONE, drop on acceptance.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rate     <= '0;
            r_rate_vld <= 1'b0;
        end else if (w_load) begin
            r_rate     <= w_rnd;
            r_rate_vld <= 1'b1;
        end else if (r_rate_vld && i_rate_rdy) begin
            r_rate_vld <= 1'b0;
        end
    end

    // Sticky overrun; a fresh overwrite beats a clear request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovr <= 1'b0;
        end else if (w_load && r_rate_vld && !i_rate_rdy) begin
            r_ovr <= 1'b1;
        end else if (i_clr_ovr) begin
            r_ovr <= 1'b0;
        end
    end

    assign o_rate     = r_rate;
    assign o_rate_vld = r_rate_vld;
    assign o_overrun  = r_ovr;
    assign o_win_cnt  = r_cnt;

endmodule

// File: tb/tb_fog_rate_accum.sv
// tb_fog_rate_accum: directed stimulus with a result scoreboard
// for the windowed rate averager.
module tb_fog_rate_accum;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_en = 1'b0;
    logic [3:0]  i_avg_log2 = 4'd0;
    logic [31:0] i_step = '0;
    logic        i_step_vld = 1'b0;
    logic [31:0] o_rate;
    logic        o_rate_vld;
    logic        i_rate_rdy = 1'b1;
    logic        o_overrun;
    logic        i_clr_ovr = 1'b0;
    logic [10:0] o_win_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] q_exp[$];

    fog_rate_accum #(
        .STEP_W   (32),
        .ACC_W    (48),
        .MAX_LOG2 (10)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_avg_log2 (i_avg_log2),
        .i_step     (i_step),
        .i_step_vld (i_step_vld),
        .o_rate     (o_rate),
        .o_rate_vld (o_rate_vld),
        .i_rate_rdy (i_rate_rdy),
        .o_overrun  (o_overrun),
        .i_clr_ovr  (i_clr_ovr),
        .o_win_cnt  (o_win_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Mean of sum over 2^k, rounded half up, clamped to 32-bit signed.
    function automatic logic [31:0] model(input longint sum, input int k);
        longint d;
        longint v;
        longint qt;
        d = longint'(1) << k;
        v = sum + ((k > 0) ? d / 2 : 0);
        qt = v / d;
        if ((v % d) != 0 && v < 0) qt = qt - 1;
        if (qt > 64'sd2147483647) qt = 64'sd2147483647;
        if (qt < -64'sd2147483648) qt = -64'sd2147483648;
        return qt[31:0];
    endfunction

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] s);
        i_step_vld = 1'b1;
        i_step = s;
        cyc();
        i_step_vld = 1'b0;
    endtask

    task automatic start(input logic [3:0] k);
        i_en = 1'b0;
        cyc();
        cyc();
        i_avg_log2 = k;
        i_en = 1'b1;
        cyc();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && q_exp.size() != 0; i++) cyc();
        chk(tag, q_exp.size(), 0);
    endtask

    // Every word the consumer takes is checked against the scoreboard.
    always @(negedge i_clk) begin
        if (!i_rst && o_rate_vld && i_rate_rdy) begin
            if (q_exp.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected: got=%0h exp=none", o_rate);
            end else begin
                chk("rate", o_rate, q_exp.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        chk("rst_rate", o_rate, 0);
        chk("rst_vld", o_rate_vld, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_cnt", o_win_cnt, 0);
        i_rst = 1'b0;
        cyc();

        // k=2 window, slow strobes
        start(4'd2);
        strobe(32'd10);
        repeat (99) cyc();
        strobe(32'd20);
        repeat (99) cyc();
        strobe(32'd30);
        chk("win_cnt3", o_win_cnt, 3);
        repeat (99) cyc();
        q_exp.push_back(model(101, 2));
        strobe(32'd41);
        chk("lat_n", o_rate_vld, 0);
        cyc();
        chk("lat_n1", o_rate_vld, 1);
        drain("drain_avg");

        // k=1 rounding and sign
        start(4'd1);
        q_exp.push_back(model(-5, 1));
        strobe(-32'sd3);
        cyc();
        strobe(-32'sd2);
        repeat (3) cyc();
        q_exp.push_back(model(5, 1));
        strobe(32'd3);
        cyc();
        strobe(32'd2);
        drain("drain_round");

        // pass-through and extremes
        start(4'd0);
        q_exp.push_back(model(longint'(32'h7FFFFFFF), 0));
        strobe(32'h7FFFFFFF);
        repeat (3) cyc();
        q_exp.push_back(model(-(longint'(1) << 31), 0));
        strobe(32'h80000000);
        drain("drain_k0");
        start(4'd1);
        q_exp.push_back(model(longint'(32'h7FFFFFFF) * 2, 1));
        strobe(32'h7FFFFFFF);
        strobe(32'h7FFFFFFF);
        repeat (3) cyc();
        q_exp.push_back(model(-(longint'(1) << 32), 1));
        strobe(32'h80000000);
        strobe(32'h80000000);
        drain("drain_sat");

        // back-to-back strobes across DONE
        start(4'd1);
        q_exp.push_back(model(3, 1));
        q_exp.push_back(model(7, 1));
        q_exp.push_back(model(11, 1));
        i_step_vld = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            i_step = 32'(i);
            cyc();
        end
        i_step_vld = 1'b0;
        drain("drain_b2b");
        chk("b2b_ovr", o_overrun, 0);

        // overrun, clear, accept-with-reload
        start(4'd0);
        i_rate_rdy = 1'b0;
        strobe(32'd5);
        repeat (3) cyc();
        q_exp.push_back(model(7, 0));
        strobe(32'd7);
        cyc();
        chk("ovr_set", o_overrun, 1);
        chk("ovr_vld", o_rate_vld, 1);
        i_clr_ovr = 1'b1;
        cyc();
        i_clr_ovr = 1'b0;
        chk("ovr_clr", o_overrun, 0);
        i_rate_rdy = 1'b1;
        drain("drain_ovr");
        cyc();
        i_rate_rdy = 1'b0;
        q_exp.push_back(model(9, 0));
        strobe(32'd9);
        repeat (3) cyc();
        q_exp.push_back(model(11, 0));
        strobe(32'd11);
        i_rate_rdy = 1'b1;
        cyc();
        chk("same_vld", o_rate_vld, 1);
        drain("drain_same");
        chk("same_ovr", o_overrun, 0);

        // enable drop discards partial window
        start(4'd2);
        strobe(32'd1);
        strobe(32'd2);
        strobe(32'd3);
        chk("part_cnt", o_win_cnt, 3);
        i_en = 1'b0;
        cyc();
        chk("drop_cnt", o_win_cnt, 0);
        i_en = 1'b1;
        cyc();
        q_exp.push_back(model(32, 2));
        for (int i = 0; i < 4; i++) strobe(32'd8);
        drain("drain_drop");

        // asynchronous reset mid-window
        i_rate_rdy = 1'b0;
        start(4'd0);
        strobe(32'd5);
        cyc();
        strobe(32'd6);
        cyc();
        i_en = 1'b0;
        cyc();
        i_avg_log2 = 4'd2;
        i_en = 1'b1;
        cyc();
        strobe(32'd1);
        chk("pre_vld", o_rate_vld, 1);
        chk("pre_ovr", o_overrun, 1);
        chk("pre_cnt", o_win_cnt, 1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("arst_rate", o_rate, 0);
        chk("arst_vld", o_rate_vld, 0);
        chk("arst_ovr", o_overrun, 0);
        chk("arst_cnt", o_win_cnt, 0);
        cyc();
        i_rst = 1'b0;
        i_rate_rdy = 1'b1;
        repeat (3) cyc();
        drain("drain_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
